// File: rtl/forward_tracker.sv
// Operand forwarding scoreboard beside the ID stage: tracks in-flight destination
// registers, selects the youngest producer per source and raises load-use stalls.
module forward_tracker #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 3,
  parameter int NUM_SRC = 2,
  parameter int SLOT_W  = 3
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      freeze,
  input  logic                      flush,
  input  logic                      id_valid,
  input  logic [4:0]                id_rd,
  input  logic                      id_reg_write,
  input  logic [SLOT_W-1:0]         id_result_stage,
  input  logic [NUM_SRC*5-1:0]      id_rs_addr,
  input  logic [NUM_SRC-1:0]        id_rs_used,
  input  logic [DEPTH*XLEN-1:0]     stage_data,
  output logic [NUM_SRC-1:0]        fwd_hit,
  output logic [NUM_SRC*SLOT_W-1:0] fwd_slot,
  output logic [NUM_SRC*XLEN-1:0]   fwd_data,
  output logic                      stall,
  output logic [31:0]               stall_count
);

  logic [DEPTH-1:0]  slot_valid;
  logic [4:0]        slot_rd     [DEPTH];
  logic [SLOT_W-1:0] slot_rstage [DEPTH];
  logic [31:0]       stall_cnt;
  logic [NUM_SRC-1:0] src_wait;
  logic              insert_bubble;

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_hit  = '0;
    fwd_slot = '0;
    fwd_data = '0;
    src_wait = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (slot_valid[k] && id_rs_used[i] &&
            (id_rs_addr[5*i +: 5] != 5'd0) &&
            (slot_rd[k] == id_rs_addr[5*i +: 5])) begin
          fwd_hit[i]                   = 1'b1;
          fwd_slot[SLOT_W*i +: SLOT_W] = SLOT_W'(k);
          fwd_data[XLEN*i +: XLEN]     = stage_data[XLEN*k +: XLEN];
          src_wait[i]                  = (slot_rstage[k] > SLOT_W'(k));
        end
      end
    end
  end

  assign stall         = id_valid & ~flush & (|src_wait);
  assign insert_bubble = stall | flush | ~id_valid | ~id_reg_write | (id_rd == 5'd0);
  assign stall_count   = stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid <= '0;
      stall_cnt  <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        slot_rd[k]     <= '0;
        slot_rstage[k] <= '0;
      end
    end else if (!freeze) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        slot_valid[k]  <= slot_valid[k-1];
        slot_rd[k]     <= slot_rd[k-1];
        slot_rstage[k] <= slot_rstage[k-1];
      end
      slot_valid[0]  <= ~insert_bubble;
      slot_rd[0]     <= insert_bubble ? 5'd0 : id_rd;
      slot_rstage[0] <= insert_bubble ? '0 : id_result_stage;
      if (stall && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_forward_tracker.sv
// Directed bench for forward_tracker: expected outputs are queued as each ID
// instruction is driven and compared against the DUT on the falling edge.
module tb_forward_tracker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        freeze, flush, id_valid, id_reg_write;
  logic [4:0]  id_rd;
  logic [2:0]  id_result_stage;
  logic [9:0]  id_rs_addr;
  logic [1:0]  id_rs_used;
  logic [31:0] sd0, sd1, sd2;
  logic [95:0] stage_data;
  logic [1:0]  fwd_hit;
  logic [5:0]  fwd_slot;
  logic [63:0] fwd_data;
  logic        stall;
  logic [31:0] stall_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [1:0]  hit;
    logic [5:0]  slot;
    logic [63:0] data;
    logic        stall;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  assign stage_data = {sd2, sd1, sd0};

  always #5 clk = ~clk;

  forward_tracker #(.XLEN(32), .DEPTH(3), .NUM_SRC(2), .SLOT_W(3)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .freeze          (freeze),
    .flush           (flush),
    .id_valid        (id_valid),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_result_stage (id_result_stage),
    .id_rs_addr      (id_rs_addr),
    .id_rs_used      (id_rs_used),
    .stage_data      (stage_data),
    .fwd_hit         (fwd_hit),
    .fwd_slot        (fwd_slot),
    .fwd_data        (fwd_data),
    .stall           (stall),
    .stall_count     (stall_count)
  );

  task automatic apply(input logic v, input logic [4:0] rd, input logic rw,
                       input logic [2:0] rstage, input logic [4:0] a0,
                       input logic [4:0] a1, input logic [1:0] used,
                       input logic fl, input logic fz);
    id_valid        = v;
    id_rd           = rd;
    id_reg_write    = rw;
    id_result_stage = rstage;
    id_rs_addr      = {a1, a0};
    id_rs_used      = used;
    flush           = fl;
    freeze          = fz;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] hit,
                            input logic [2:0] s0, input logic [2:0] s1,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input logic st, input logic [31:0] cnt);
    exp_t e;
    e.tag   = tag;
    e.hit   = hit;
    e.slot  = {s1, s0};
    e.data  = {d1, d0};
    e.stall = st;
    e.cnt   = cnt;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL scoreboard_empty got size %0d want >0", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (fwd_hit === e.hit) else begin
        failures++;
        $error("FAIL %s.hit got %b want %b", e.tag, fwd_hit, e.hit);
      end
      checks++;
      assert (fwd_slot === e.slot) else begin
        failures++;
        $error("FAIL %s.slot got %h want %h", e.tag, fwd_slot, e.slot);
      end
      checks++;
      assert (fwd_data === e.data) else begin
        failures++;
        $error("FAIL %s.data got %h want %h", e.tag, fwd_data, e.data);
      end
      checks++;
      assert (stall === e.stall) else begin
        failures++;
        $error("FAIL %s.stall got %b want %b", e.tag, stall, e.stall);
      end
      checks++;
      assert (stall_count === e.cnt) else begin
        failures++;
        $error("FAIL %s.stall_count got %h want %h", e.tag, stall_count, e.cnt);
      end
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    sd0 = '0; sd1 = '0; sd2 = '0;
    apply(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    expect_out("reset", 2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk); check_out();
    reset_n = 1'b1;

    // back-to-back ALU
    next_edge(); apply(1, 5, 1, 0, 0, 0, 2'b00, 0, 0);
    expect_out("addi_x5", 2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk); check_out();
    next_edge(); sd0 = 32'h1234; apply(1, 0, 0, 0, 5, 0, 2'b01, 0, 0);
    expect_out("alu_fwd", 2'b01, 0, 0, 32'h1234, 0, 0, 0);
    @(negedge clk); check_out();

    // load-use
    next_edge(); apply(1, 7, 1, 1, 0, 0, 2'b00, 0, 0);
    expect_out("lw_x7", 2'b00, 0, 0, 0, 0, 0, 0);
    @(negedge clk); check_out();
    next_edge(); sd0 = 32'hAAAA; apply(1, 8, 1, 0, 0, 7, 2'b10, 0, 0);
    expect_out("load_use_stall", 2'b10, 0, 0, 0, 32'hAAAA, 1, 0);
    @(negedge clk); check_out();
    next_edge(); sd1 = 32'hDEADBEEF;
    expect_out("load_use_resolved", 2'b10, 0, 1, 0, 32'hDEADBEEF, 0, 1);
    @(negedge clk); check_out();

    // youngest wins: slots become (x3, x9, x3)
    next_edge(); apply(1, 3, 1, 0, 0, 0, 2'b00, 0, 0);
    expect_out("setup_x3a", 2'b00, 0, 0, 0, 0, 0, 1);
    @(negedge clk); check_out();
    next_edge(); apply(1, 9, 1, 0, 0, 0, 2'b00, 0, 0);
    expect_out("setup_x9", 2'b00, 0, 0, 0, 0, 0, 1);
    @(negedge clk); check_out();
    next_edge(); apply(1, 3, 1, 0, 0, 0, 2'b00, 0, 0);
    expect_out("setup_x3b", 2'b00, 0, 0, 0, 0, 0, 1);
    @(negedge clk); check_out();
    next_edge(); sd0 = 32'h22; sd1 = 32'h99; sd2 = 32'h11;
    apply(1, 0, 0, 0, 3, 9, 2'b11, 0, 0);
    expect_out("youngest_wins", 2'b11, 0, 1, 32'h22, 32'h99, 0, 1);
    @(negedge clk); check_out();

    // not-ready youngest load, ready older copy: slots become (x3L, x10, x3)
    next_edge(); apply(1, 3, 1, 0, 0, 0, 2'b00, 0, 0);
    expect_out("setup_x3c", 2'b00, 0, 0, 0, 0, 0, 1);
    @(negedge clk); check_out();
    next_edge(); apply(1, 10, 1, 0, 0, 0, 2'b00, 0, 0);
    expect_out("setup_x10", 2'b00, 0, 0, 0, 0, 0, 1);
    @(negedge clk); check_out();
    next_edge(); apply(1, 3, 1, 1, 0, 0, 2'b00, 0, 0);
    expect_out("setup_lw_x3", 2'b00, 0, 0, 0, 0, 0, 1);
    @(negedge clk); check_out();
    next_edge(); apply(1, 0, 0, 0, 3, 0, 2'b01, 0, 0);
    expect_out("no_fallback", 2'b01, 0, 0, 32'h22, 0, 1, 1);
    @(negedge clk); check_out();

    // freeze during the stall
    apply(1, 0, 0, 0, 3, 0, 2'b01, 0, 1);
    for (int n = 0; n < 3; n++) begin
      next_edge();
      expect_out("freeze_hold", 2'b01, 0, 0, 32'h22, 0, 1, 1);
      @(negedge clk); check_out();
    end
    apply(1, 0, 0, 0, 3, 0, 2'b01, 0, 0);
    next_edge(); sd1 = 32'h33;
    expect_out("after_freeze", 2'b01, 1, 0, 32'h33, 0, 0, 2);
    @(negedge clk); check_out();

    // flush
    next_edge(); apply(1, 12, 1, 1, 0, 0, 2'b00, 0, 0);
    expect_out("lw_x12", 2'b00, 0, 0, 0, 0, 0, 2);
    @(negedge clk); check_out();
    next_edge(); sd0 = 32'h55; apply(1, 14, 1, 1, 12, 0, 2'b01, 1, 0);
    expect_out("flush_no_stall", 2'b01, 0, 0, 32'h55, 0, 0, 2);
    @(negedge clk); check_out();
    next_edge(); sd1 = 32'h66; apply(1, 0, 0, 0, 12, 14, 2'b11, 0, 0);
    expect_out("flush_bubble", 2'b01, 1, 0, 32'h66, 0, 0, 2);
    @(negedge clk); check_out();

    // x0 and unused sources
    next_edge(); apply(1, 0, 1, 0, 0, 0, 2'b00, 0, 0);
    expect_out("write_x0", 2'b00, 0, 0, 0, 0, 0, 2);
    @(negedge clk); check_out();
    next_edge(); apply(1, 6, 1, 1, 0, 0, 2'b00, 0, 0);
    expect_out("lw_x6", 2'b00, 0, 0, 0, 0, 0, 2);
    @(negedge clk); check_out();
    next_edge(); apply(1, 0, 0, 0, 0, 6, 2'b01, 0, 0);
    expect_out("x0_unused", 2'b00, 0, 0, 0, 0, 0, 2);
    @(negedge clk); check_out();

    // fill slots, then reset mid-stream
    for (int r = 20; r <= 22; r++) begin
      next_edge(); apply(1, 5'(r), 1, 0, 0, 0, 2'b00, 0, 0);
      expect_out("fill", 2'b00, 0, 0, 0, 0, 0, 2);
      @(negedge clk); check_out();
    end
    next_edge(); sd2 = 32'h77; apply(1, 0, 0, 0, 20, 0, 2'b01, 0, 0);
    expect_out("pre_reset", 2'b01, 2, 0, 32'h77, 0, 0, 2);
    @(negedge clk); check_out();
    #2 reset_n = 1'b0;
    #1;
    expect_out("reset_mid", 2'b00, 0, 0, 0, 0, 0, 0);
    check_out();
    @(negedge clk); reset_n = 1'b1;
    #1;
    expect_out("post_reset_empty", 2'b00, 0, 0, 0, 0, 0, 0);
    check_out();

    // saturation
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1 release dut.stall_cnt;
    next_edge(); apply(1, 7, 1, 1, 0, 0, 2'b00, 0, 0);
    expect_out("sat_lw_x7", 2'b00, 0, 0, 0, 0, 0, 32'hFFFF_FFFE);
    @(negedge clk); check_out();
    next_edge(); sd0 = 32'hA0; apply(1, 8, 1, 1, 7, 0, 2'b01, 0, 0);
    expect_out("sat_stall1", 2'b01, 0, 0, 32'hA0, 0, 1, 32'hFFFF_FFFE);
    @(negedge clk); check_out();
    next_edge(); sd1 = 32'hB1;
    expect_out("sat_resolve1", 2'b01, 1, 0, 32'hB1, 0, 0, 32'hFFFF_FFFF);
    @(negedge clk); check_out();
    next_edge(); sd0 = 32'hC2; apply(1, 0, 0, 0, 8, 0, 2'b01, 0, 0);
    expect_out("sat_stall2", 2'b01, 0, 0, 32'hC2, 0, 1, 32'hFFFF_FFFF);
    @(negedge clk); check_out();
    next_edge(); sd1 = 32'hD3;
    expect_out("saturated", 2'b01, 1, 0, 32'hD3, 0, 0, 32'hFFFF_FFFF);
    @(negedge clk); check_out();

    checks++;
    assert (sb.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain got %0d want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/forward_tracker.md
Name: forward_tracker

Overview:
- Parametrised successor to the single-stage EX/MEM forwarding mux.
- Sits beside the ID stage. Holds a shift-register scoreboard of the destination registers of DEPTH in-flight instructions (slot 0 = EX, slot 1 = MEM, slot 2 = WB, ...).
- For each of NUM_SRC source operands it selects the youngest matching producer's data and reports whether the operand comes from the register file or from a pipeline slot.
- Raises a load-use style stall when the matching producer's result is not yet available, and counts stall cycles.

Parameters:
- XLEN, 32, data width.
- DEPTH, 3, number of tracked in-flight slots (1..7).
- NUM_SRC, 2, number of source operands checked per cycle.
- SLOT_W, 3, width of slot index and result-stage fields; must satisfy 2^SLOT_W > DEPTH.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- freeze  in  1  global pipeline hold; all state holds.
- flush  in  1  ID instruction is killed (branch/jump redirect).
- id_valid  in  1  ID stage holds a real instruction.
- id_rd  in  5  destination register of the ID instruction.
- id_reg_write  in  1  ID instruction writes the register file.
- id_result_stage  in  SLOT_W  first slot index at which its result is valid: ALU/LUI/JAL = 0, LOAD/CSR = 1.
- id_rs_addr  in  NUM_SRC*5  source register addresses, source i at bits [5i+4:5i].
- id_rs_used  in  NUM_SRC  source i is actually read.
- stage_data  in  DEPTH*XLEN  result value currently held by slot k, at bits [XLEN*k +: XLEN].
- fwd_hit  out  NUM_SRC  source i is forwarded.
- fwd_slot  out  NUM_SRC*SLOT_W  slot index supplying source i; 0 when no hit.
- fwd_data  out  NUM_SRC*XLEN  forwarded value; 0 when no hit.
- stall  out  1  hold IF/ID and inject a bubble into EX.
- stall_count  out  32  saturating count of stall cycles.

Behaviour:
- State per slot: valid, rd, result_stage. Also stall_count.
- Reset (async, reset_n=0): all slots invalid, rd=0, result_stage=0, stall_count=0. The outputs fwd_hit, fwd_slot, fwd_data, stall and stall_count are all 0 during and after reset until new instructions are inserted.
- Match: slot k matches source i when all of the following hold: slot valid, slot rd == rs_i, rs_i != 0, id_rs_used[i]=1.
  - The lowest matching k wins (youngest producer).
  - No match means fwd_hit=0: the operand comes from the register file.
- Forward (combinational, zero latency): on a match, fwd_hit[i]=1, fwd_slot=k, fwd_data=stage_data[k].
- Not-ready rule: a winning slot with result_stage > k is not ready and asserts stall.
  - fwd_hit and fwd_data still reflect that slot but are don't-care to the pipeline.
  - An older, ready match must NOT be used instead.
- stall = id_valid & ~flush & (any source winner not ready).
- Shift at posedge clk when freeze=0:
  - slot[k] <= slot[k-1] for k>=1.
  - slot0 <= bubble (valid=0) if stall | flush | ~id_valid | ~id_reg_write | id_rd==0.
  - Otherwise slot0 <= {1, id_rd, id_result_stage}.
  - Slot DEPTH-1 falls off.
- freeze=1: all slots and stall_count hold. Outputs still evaluate combinationally. freeze has priority over flush and stall.
- stall_count increments by 1 on each clock with stall=1 & freeze=0, and saturates at 32'hFFFFFFFF (no wrap).
- Stall resolution timing: a load (result_stage=1) in slot 0 stalls the dependent instruction for exactly one cycle. The load then moves to slot 1, which is ready, and the bubble occupies slot 0.
- Reset asserted mid-operation clears everything immediately. The first instruction after release sees an empty scoreboard.
- rd=x0 is never recorded and never matched.

Test Plan:
- Back-to-back ALU: ID "addi x5" (result_stage 0), next cycle ID reads rs1=x5 with stage_data[0]=0x1234 -> fwd_hit[0]=1, fwd_slot=0, fwd_data=0x1234, stall=0.
- Load-use: ID "lw x7" (result_stage 1), next cycle rs2=x7 -> stall=1 for one cycle, stall_count 0->1. Following cycle: fwd_slot=1, fwd_data=stage_data[1]=0xDEADBEEF, stall=0.
- Youngest wins: x3 written by slot 2 (0x11) and slot 0 (0x22), both ready -> fwd_slot=0, fwd_data=0x22. Same setup with slot 0 a not-ready load -> stall=1, no fallback to slot 2.
- x0 and unused sources: instruction writes x0, then rs1=x0 -> fwd_hit=0. id_rs_used[1]=0 with a matching rs2 -> fwd_hit[1]=0, stall=0.
- freeze/flush: freeze=1 for 3 cycles during a load-use stall -> slots and stall_count unchanged. flush=1 with a dependent ID -> stall=0 and a bubble is inserted into slot 0.
- Reset mid-stream: reset_n low while slots are full -> all outputs 0 immediately. After release, rs1 matching an old rd -> fwd_hit=0. stall_count forced to 32'hFFFFFFFE and two stall cycles applied -> saturates at 32'hFFFFFFFF.
